result_drain: RTL and testbench

Downstream stage of the systolic top. Captures the `ROWS*ACC_W` accumulator vector (`result_flat`) on a one-cycle `capture` pulse and requantizes each row to `DW` bits: rounding arithmetic right shift, saturation, optional ReLU. It then streams the rows out one per beat over a valid/ready interface in row order 0..ROWS-1. It decouples the compute array from a slower consumer: the array may start the next job while draining is in progress.

---
 rtl/result_drain.sv | 140 ++++++++++++++
 tb/tb_result_drain.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// Captures an accumulator vector, requantizes each row (round, saturate, optional ReLU)
// and streams the rows out over valid/ready so the array can start the next job early.
module result_drain #(
    parameter int DW      = 8,
    parameter int ROWS    = 8,
    parameter int ACC_W   = 16,
    parameter int ROW_W   = 3,
    parameter int SHIFT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture,
    input  logic [ROWS*ACC_W-1:0] result_flat,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic                  relu_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [ROW_W-1:0]      out_row,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic {IDLE, DRAIN} state_e;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DW+2){1'b1}}, {(DW-1){1'b0}}};

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     buf_q [ROWS];
    logic [ACC_W-1:0]     buf_d [ROWS];
    logic [ROW_W-1:0]     row_q, row_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic                 relu_q, relu_d;
    logic                 overrun_q, overrun_d;

    logic                 handshake;
    logic                 at_last;
    logic signed [ACC_W:0] cur_ext, rnd, t_sum, q_shr;
    logic signed [DW-1:0]  sat;

    assign at_last   = (row_q == LAST_ROW);
    assign handshake = (state_q == DRAIN) && out_ready;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        row_d     = row_q;
        shift_d   = shift_q;
        relu_d    = relu_q;
        overrun_d = overrun_q;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    for (int unsigned r = 0; r < ROWS; r++) begin
                        buf_d[r] = result_flat[r*ACC_W +: ACC_W];
                    end
                    shift_d = shift;
                    relu_d  = relu_en;
                    row_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A capture is only accepted when it coincides with the final handshake.
                if (handshake && at_last) begin
                    row_d = '0;
                    if (capture) begin
                        for (int unsigned r = 0; r < ROWS; r++) begin
                            buf_d[r] = result_flat[r*ACC_W +: ACC_W];
                        end
                        shift_d = shift;
                        relu_d  = relu_en;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (handshake) begin
                        row_d = row_q + 1'b1;
                    end
                    if (capture) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            for (int unsigned r = 0; r < ROWS; r++) begin
                buf_q[r] <= '0;
            end
            row_q     <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            row_q     <= row_d;
            shift_q   <= shift_d;
            relu_q    <= relu_d;
            overrun_q <= overrun_d;
        end
    end

    // One extra bit of headroom so adding the rounding constant never overflows.
    always_comb begin
        cur_ext = {buf_q[row_q][ACC_W-1], buf_q[row_q]};
        rnd     = '0;
        if (shift_q != '0) begin
            rnd = (ACC_W+1)'(1) << (shift_q - 1'b1);
        end
        t_sum = cur_ext + rnd;
        q_shr = t_sum >>> shift_q;
        if (q_shr > SAT_MAX) begin
            sat = SAT_MAX[DW-1:0];
        end else if (q_shr < SAT_MIN) begin
            sat = SAT_MIN[DW-1:0];
        end else begin
            sat = q_shr[DW-1:0];
        end
        if (relu_q && sat[DW-1]) begin
            sat = '0;
        end
    end

    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == DRAIN);
    assign out_row   = row_q;
    assign out_last  = (state_q == DRAIN) && at_last;
    assign out_data  = (state_q == DRAIN) ? sat : '0;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: drain values, rounding, ReLU/saturation,
// backpressure, overrun vs back-to-back capture, and reset mid-drain.
module tb_result_drain;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         capture;
    logic [127:0] result_flat;
    logic [3:0]   shift;
    logic         relu_en;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [2:0]   out_row;
    logic         out_last;
    logic         busy;
    logic         overrun;

    int checks   = 0;
    int failures = 0;

    logic signed [15:0] vin [8];
    logic signed [7:0]  exp_v [8];

    result_drain #(
        .DW      (8),
        .ROWS    (8),
        .ACC_W   (16),
        .ROW_W   (3),
        .SHIFT_W (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture     (capture),
        .result_flat (result_flat),
        .shift       (shift),
        .relu_en     (relu_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_vin();
        for (int r = 0; r < 8; r++) begin
            result_flat[r*16 +: 16] = vin[r];
        end
    endtask

    task automatic do_capture(input logic [3:0] s, input logic relu);
        pack_vin();
        shift   = s;
        relu_en = relu;
        capture = 1'b1;
        step();
        capture = 1'b0;
        // Disturb sampled controls to show they only matter on the capture cycle.
        shift   = 4'd7;
        relu_en = ~relu;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; capture = 1'b0; out_ready = 1'b1;
        result_flat = '0; shift = '0; relu_en = 1'b0;
        step(); step();
        checks++;
        if (out_valid !== 1'b0 || out_row !== 3'd0 || out_last !== 1'b0 ||
            out_data !== 8'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: valid=%b row=%0d last=%b data=%0d busy=%b ovr=%b, want all 0",
                     out_valid, out_row, out_last, out_data, busy, overrun);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        vin   = '{16'sd300, -16'sd5, 16'sd1000, -16'sd1000, 16'sd5, 16'sd0, 16'sd127, -16'sd128};
        exp_v = '{8'sd75, -8'sd1, 8'sd127, -8'sd128, 8'sd1, 8'sd0, 8'sd32, -8'sd32};
        out_ready = 1'b1;
        do_capture(4'd2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_row !== 3'(i) || out_data !== exp_v[i] ||
                out_last !== (i == 7)) begin
                failures++;
                $display("FAIL basic_row%0d: valid=%b row=%0d data=%0d last=%b, want 1 %0d %0d %b",
                         i, out_valid, out_row, $signed(out_data), out_last, i, exp_v[i], (i == 7));
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: busy=%b valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_rounding();
        vin   = '{-16'sd5, 16'sd5, -16'sd1, 16'sd1, 16'sd3, -16'sd3, 16'sd0, 16'sd254};
        exp_v = '{-8'sd2, 8'sd3, 8'sd0, 8'sd1, 8'sd2, -8'sd1, 8'sd0, 8'sd127};
        out_ready = 1'b1;
        do_capture(4'd1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_row !== 3'(i) || out_data !== exp_v[i]) begin
                failures++;
                $display("FAIL round_row%0d: row=%0d data=%0d, want %0d %0d",
                         i, out_row, $signed(out_data), i, exp_v[i]);
            end
            step();
        end
    endtask

    task automatic test_relu_sat();
        vin   = '{16'sd1000, -16'sd1000, -16'sd1, 16'sd50, 16'sd0, 16'sd127, 16'sd128, -16'sd50};
        exp_v = '{8'sd127, 8'sd0, 8'sd0, 8'sd50, 8'sd0, 8'sd127, 8'sd127, 8'sd0};
        out_ready = 1'b1;
        do_capture(4'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_row !== 3'(i) || out_data !== exp_v[i]) begin
                failures++;
                $display("FAIL relu_row%0d: row=%0d data=%0d, want %0d %0d",
                         i, out_row, $signed(out_data), i, exp_v[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic pat [4];
        int   hs_cnt;
        int   cyc;
        logic hs;
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
        vin   = '{16'sd300, -16'sd5, 16'sd1000, -16'sd1000, 16'sd5, 16'sd0, 16'sd127, -16'sd128};
        exp_v = '{8'sd75, -8'sd1, 8'sd127, -8'sd128, 8'sd1, 8'sd0, 8'sd32, -8'sd32};
        hs_cnt = 0;
        cyc    = 0;
        do_capture(4'd2, 1'b0);
        while (busy === 1'b1 && cyc < 40) begin
            checks++;
            if (hs_cnt > 7 || out_row !== 3'(hs_cnt) || out_data !== exp_v[hs_cnt[2:0]] ||
                out_last !== (hs_cnt == 7)) begin
                failures++;
                $display("FAIL bp_cycle%0d: row=%0d data=%0d last=%b, want row %0d",
                         cyc, out_row, $signed(out_data), out_last, hs_cnt);
            end
            out_ready = pat[cyc % 4];
            hs = out_valid && out_ready;
            step();
            if (hs) hs_cnt++;
            cyc++;
        end
        checks++;
        if (hs_cnt != 8 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_handshakes: count=%0d busy=%b after %0d cycles, want 8 0",
                     hs_cnt, busy, cyc);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        vin   = '{16'sd300, -16'sd5, 16'sd1000, -16'sd1000, 16'sd5, 16'sd0, 16'sd127, -16'sd128};
        exp_v = '{8'sd75, -8'sd1, 8'sd127, -8'sd128, 8'sd1, 8'sd0, 8'sd32, -8'sd32};
        out_ready = 1'b1;
        do_capture(4'd2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_row !== 3'(i) || out_data !== exp_v[i]) begin
                failures++;
                $display("FAIL b2b_first_row%0d: row=%0d data=%0d, want %0d %0d",
                         i, out_row, $signed(out_data), i, exp_v[i]);
            end
            if (i == 7) begin
                vin = '{-16'sd5, 16'sd5, -16'sd1, 16'sd1, 16'sd3, -16'sd3, 16'sd0, 16'sd254};
                pack_vin();
                shift = 4'd1; relu_en = 1'b0; capture = 1'b1;
            end
            step();
        end
        capture = 1'b0;
        shift   = 4'd9;
        exp_v = '{-8'sd2, 8'sd3, 8'sd0, 8'sd1, 8'sd2, -8'sd1, 8'sd0, 8'sd127};
        checks++;
        if (out_valid !== 1'b1 || out_row !== 3'd0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gapless: valid=%b row=%0d ovr=%b, want 1 0 0", out_valid, out_row, overrun);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_row !== 3'(i) || out_data !== exp_v[i]) begin
                failures++;
                $display("FAIL b2b_second_row%0d: row=%0d data=%0d, want %0d %0d",
                         i, out_row, $signed(out_data), i, exp_v[i]);
            end
            step();
        end
    endtask

    task automatic test_overrun();
        vin   = '{16'sd300, -16'sd5, 16'sd1000, -16'sd1000, 16'sd5, 16'sd0, 16'sd127, -16'sd128};
        exp_v = '{8'sd75, -8'sd1, 8'sd127, -8'sd128, 8'sd1, 8'sd0, 8'sd32, -8'sd32};
        out_ready = 1'b1;
        do_capture(4'd2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_row !== 3'(i) || out_data !== exp_v[i] || overrun !== (i > 3)) begin
                failures++;
                $display("FAIL ovr_row%0d: row=%0d data=%0d ovr=%b, want %0d %0d %b",
                         i, out_row, $signed(out_data), overrun, i, exp_v[i], (i > 3));
            end
            if (i == 3) begin
                result_flat = '1; shift = 4'd0; capture = 1'b1;
            end
            step();
            capture = 1'b0;
        end
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovr_sticky: ovr=%b busy=%b, want 1 0", overrun, busy);
        end
    endtask

    task automatic test_reset_mid();
        vin   = '{16'sd300, -16'sd5, 16'sd1000, -16'sd1000, 16'sd5, 16'sd0, 16'sd127, -16'sd128};
        out_ready = 1'b1;
        do_capture(4'd2, 1'b0);
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (out_row !== 3'd4 || out_data !== 8'sd1) begin
            failures++;
            $display("FAIL rstmid_pre: row=%0d data=%0d, want 4 1", out_row, $signed(out_data));
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_row !== 3'd0 || out_last !== 1'b0 ||
            out_data !== 8'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_values: valid=%b row=%0d last=%b data=%0d busy=%b ovr=%b, want all 0",
                     out_valid, out_row, out_last, out_data, busy, overrun);
        end
        vin   = '{-16'sd5, 16'sd5, -16'sd1, 16'sd1, 16'sd3, -16'sd3, 16'sd0, 16'sd254};
        exp_v = '{-8'sd2, 8'sd3, 8'sd0, 8'sd1, 8'sd2, -8'sd1, 8'sd0, 8'sd127};
        do_capture(4'd1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_row !== 3'(i) || out_data !== exp_v[i]) begin
                failures++;
                $display("FAIL rstmid_row%0d: valid=%b row=%0d data=%0d, want 1 %0d %0d",
                         i, out_valid, out_row, $signed(out_data), i, exp_v[i]);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_relu_sat();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
